// File: rtl/result_uart_pkg.sv
// Shared types and constants for the result UART transmitter.
// Imported by the capture FIFO and the transmitter top.
package result_uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int FRAME_BITS = 10;
  localparam int WORD_BYTES = 2;
  localparam int WORD_W     = 16;

  localparam logic [2:0] LAST_BIT = 3'd7;

endpackage

// File: rtl/result_fifo.sv
// First-word-fall-through FIFO holding captured result words.
// Extra pointer bit tells full from empty.
module result_fifo
  import result_uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_q, wr_d;
  logic [AW:0]       rd_q, rd_d;
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // A pop on the same edge frees the slot a full push needs
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_q[AW-1:0]];

  // Pointer advance
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (AW+1)'(1);
    if (do_pop)  rd_d = rd_q + (AW+1)'(1);
  end

  // Pointer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage write; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/result_uart_tx.sv
// Captures changes on the result bus and sends each word
// as two 8N1 frames, high byte first.
module result_uart_tx
  import result_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] result,
  output logic              tx,
  output logic              busy,
  output logic              overflow
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(CLKS_PER_BIT - 1);

  tx_state_t         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              bsel_q, bsel_d;
  logic [WORD_W-1:0] last_q;
  logic              ovf_q;

  logic              change;
  logic              pop;
  logic              full;
  logic              empty;
  logic [WORD_W-1:0] fifo_dout;
  logic              tick;
  logic [7:0]        cur_byte;

  assign change   = (result != last_q);
  assign tick     = (cnt_q == CNT_MAX);
  assign overflow = ovf_q;
  assign busy     = (state_q != IDLE) || !empty;

  result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (change),
    .pop   (pop),
    .din   (result),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  // Change detector and sticky drop flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= '0;
      ovf_q  <= 1'b0;
    end else if (change) begin
      last_q <= result;
      if (full && !pop) ovf_q <= 1'b1;
    end
  end

  // FSM state, bit timer and shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      bsel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      bsel_q  <= bsel_d;
    end
  end

  // Next state: frame sequencing and word pops
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    bsel_d  = bsel_q;
    pop     = 1'b0;
    if (state_q != IDLE)
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = fifo_dout;
          bsel_d  = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == LAST_BIT) state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (!bsel_q) begin
            bsel_d  = 1'b1;
            state_d = START;
          end else if (!empty) begin
            pop     = 1'b1;
            shreg_d = fifo_dout;
            bsel_d  = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Serial line level for the current state
  always_comb begin
    cur_byte = bsel_q ? shreg_q[7:0] : shreg_q[15:8];
    tx       = 1'b1;
    unique case (state_q)
      IDLE:    tx = 1'b1;
      START:   tx = 1'b0;
      DATA:    tx = cur_byte[bit_q];
      STOP:    tx = 1'b1;
      default: tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: UART line monitor plus a
// word-level model of capture, queueing and word timing.
module tb_result_uart_tx;

  localparam int C  = 4;
  localparam int FD = 4;
  localparam int WORD_CYC = 20 * C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] result = 16'h0000;
  logic        tx;
  logic        busy;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  result_uart_tx #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .result   (result),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow)
  );

  always @(posedge clk) cyc++;

  // Reference model: queue of captured words and a
  // countdown for the word currently on the line.
  logic [15:0] m_q[$];
  int          exp_q[$];
  logic [15:0] m_last;
  logic [15:0] m_w;
  int          m_rem;
  logic        m_ovf;
  bit          m_pop;
  bit          m_full;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      exp_q.delete();
      m_last = 16'h0;
      m_rem  = 0;
      m_ovf  = 1'b0;
    end else begin
      m_pop  = (m_q.size() > 0) && (m_rem <= 1);
      m_full = (m_q.size() == FD);
      if (m_pop) begin
        m_w = m_q.pop_front();
        exp_q.push_back(int'(m_w[15:8]));
        exp_q.push_back(int'(m_w[7:0]));
        m_rem = WORD_CYC;
      end else if (m_rem > 0) begin
        m_rem--;
      end
      if (result != m_last) begin
        m_last = result;
        if (m_full && !m_pop) m_ovf = 1'b1;
        else m_q.push_back(result);
      end
    end
  end

  function automatic logic m_busy();
    return (m_rem > 0) || (m_q.size() > 0);
  endfunction

  // UART monitor: samples tx in the middle of each bit.
  // Framing errors are recorded as -1.
  int         got_q[$];
  int         mstart[$];
  int         mst;
  int         moff;
  int         mk;
  logic [7:0] msh;

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      mst = 0;
      got_q.delete();
      mstart.delete();
    end else if (mst == 0) begin
      if (tx === 1'b0) begin
        mst  = 1;
        moff = 0;
        mstart.push_back(cyc);
      end
    end else begin
      moff++;
      if (moff % C == C / 2) begin
        mk = moff / C;
        if (mk == 0 && tx !== 1'b0) begin
          mst = 0;
        end else if (mk >= 1 && mk <= 8) begin
          msh[mk-1] = tx;
        end else if (mk == 9) begin
          if (tx === 1'b1) got_q.push_back(int'(msh));
          else got_q.push_back(-1);
          mst = 0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] r);
    result = r;
    reset  = 1'b1;
    tick();
    tick();
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    result = 16'h0;
    reset  = 1'b1;
    tick();
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_tx: got %b want 1", tx);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b want 0", overflow);
    end
    reset = 1'b0;
    bad = 0;
    repeat (100) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || got_q.size() != 0) begin
      errors++;
      $display("FAIL idle_quiet: bad cycles %0d frames %0d want 0 0",
               bad, got_q.size());
    end
  endtask

  task automatic test_single();
    int want[2] = '{8'hA5, 8'h5A};
    result = 16'hA55A;
    tick();
    checks++;
    if (busy !== 1'b1 || tx !== 1'b1) begin
      errors++;
      $display("FAIL capture_edge: busy %b tx %b want 1 1", busy, tx);
    end
    tick();
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL start_latency: tx %b want 0", tx);
    end
    repeat (WORD_CYC - 1) tick();
    checks++;
    if (busy !== 1'b1 || tx !== 1'b1) begin
      errors++;
      $display("FAIL last_stop: busy %b tx %b want 1 1", busy, tx);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL word_len: busy %b want 0", busy);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== want[i]) begin
        errors++;
        $display("FAIL single_byte%0d: got %0h want %0h", i,
                 (i < got_q.size()) ? got_q[i] : -1, want[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int want[6] = '{0, 1, 0, 2, 0, 3};
    do_reset(16'h0);
    result = 16'h0001;
    tick();
    result = 16'h0002;
    tick();
    result = 16'h0003;
    tick();
    repeat (3 * WORD_CYC + 10) tick();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== want[i]) begin
        errors++;
        $display("FAIL b2b_byte%0d: got %0h want %0h", i,
                 (i < got_q.size()) ? got_q[i] : -1, want[i]);
      end
    end
    checks++;
    if (mstart.size() != 6) begin
      errors++;
      $display("FAIL b2b_frames: got %0d want 6", mstart.size());
    end else begin
      for (int i = 1; i < 6; i++) begin
        checks++;
        if (mstart[i] - mstart[i-1] != 10 * C) begin
          errors++;
          $display("FAIL b2b_gap%0d: got %0d want %0d", i,
                   mstart[i] - mstart[i-1], 10 * C);
        end
      end
    end
    checks++;
    if (overflow !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_flags: ovf %b busy %b want 0 0",
               overflow, busy);
    end
  endtask

  task automatic test_overflow();
    int want[10] = '{0, 1, 0, 2, 0, 3, 0, 4, 0, 5};
    do_reset(16'h0);
    for (int v = 1; v <= 7; v++) begin
      result = 16'(v);
      tick();
      checks++;
      if (overflow !== (v >= 6)) begin
        errors++;
        $display("FAIL ovf_after_v%0d: got %b want %b",
                 v, overflow, (v >= 6));
      end
    end
    repeat (5 * WORD_CYC + 20) tick();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== want[i]) begin
        errors++;
        $display("FAIL ovf_byte%0d: got %0h want %0h", i,
                 (i < got_q.size()) ? got_q[i] : -1, want[i]);
      end
    end
    checks++;
    if (got_q.size() != 10 || overflow !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ovf_end: bytes %0d ovf %b busy %b want 10 1 0",
               got_q.size(), overflow, busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(16'h0);
    result = 16'hFFFF;
    tick();
    tick();
    repeat (3 * C) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: got %b want 1", busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: tx %b busy %b ovf %b want 1 0 0",
               tx, busy, overflow);
    end
    result = 16'h0;
    tick();
    reset = 1'b0;
    repeat (60) tick();
    checks++;
    if (busy !== 1'b0 || got_q.size() != 0 || mstart.size() != 0) begin
      errors++;
      $display("FAIL mid_quiet: busy %b frames %0d want 0 0",
               busy, mstart.size());
    end
  endtask

  task automatic test_reset_capture();
    int want[2] = '{8'h12, 8'h34};
    result = 16'h1234;
    reset  = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rc_busy: got %b want 1", busy);
    end
    tick();
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL rc_start: tx %b want 0", tx);
    end
    repeat (WORD_CYC + 5) tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== want[i]) begin
        errors++;
        $display("FAIL rc_byte%0d: got %0h want %0h", i,
                 (i < got_q.size()) ? got_q[i] : -1, want[i]);
      end
    end
  endtask

  task automatic test_random();
    int n;
    int bad;
    do_reset(16'h0);
    bad = 0;
    for (int i = 0; i <= 40; i++) begin
      if (i < 40) begin
        result = 16'($urandom);
        n = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(1, 120);
      end else begin
        n = FD * WORD_CYC + 2 * WORD_CYC;
      end
      repeat (n) begin
        tick();
        checks++;
        if (busy !== m_busy() || overflow !== m_ovf ||
            (m_rem == 0 && tx !== 1'b1)) begin
          errors++;
          if (bad < 5)
            $display("FAIL rand_cyc%0d: busy %b ovf %b tx %b want %b %b",
                     cyc, busy, overflow, tx, m_busy(), m_ovf);
          bad++;
        end
      end
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d want %0d",
               got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand_byte%0d: got %0h want %0h",
                   i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_reset_capture();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
